mem_stage: RTL

//  Pipeline MEM stage; consumes the ex_mem_* bundle produced by the EX stage.

---
 rtl/mem_stage_if.sv | 35 +++
 rtl/mem_stage.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// EX/MEM input bundle, registered MEM/WB output bundle, plus upstream stall and fault pulse.
// The MEM stage takes the slave side; whatever drives EX/MEM and consumes MEM/WB takes the master side.
interface mem_stage_if;
  logic [63:0] ex_mem_alu_result;
  logic [63:0] ex_mem_rs2_val;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_Memwrite;
  logic        ex_mem_Memread;
  logic        ex_mem_MemtoReg;
  logic        ex_mem_Regwrite;
  logic        ex_mem_overflow;

  logic [63:0] mem_wb_alu_result;
  logic [63:0] mem_wb_read_data;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_MemtoReg;
  logic        mem_wb_Regwrite;
  logic        mem_wb_overflow;
  logic        mem_stall;
  logic        mem_fault;

  modport master (
    output ex_mem_alu_result, ex_mem_rs2_val, ex_mem_rd, ex_mem_Memwrite,
           ex_mem_Memread, ex_mem_MemtoReg, ex_mem_Regwrite, ex_mem_overflow,
    input  mem_wb_alu_result, mem_wb_read_data, mem_wb_rd, mem_wb_MemtoReg,
           mem_wb_Regwrite, mem_wb_overflow, mem_stall, mem_fault
  );

  modport slave (
    input  ex_mem_alu_result, ex_mem_rs2_val, ex_mem_rd, ex_mem_Memwrite,
           ex_mem_Memread, ex_mem_MemtoReg, ex_mem_Regwrite, ex_mem_overflow,
    output mem_wb_alu_result, mem_wb_read_data, mem_wb_rd, mem_wb_MemtoReg,
           mem_wb_Regwrite, mem_wb_overflow, mem_stall, mem_fault
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: 64-bit doubleword load/store to a local RAM taking MEM_LATENCY cycles per access.
// mem_stall holds upstream for MEM_LATENCY-1 cycles per valid access; faulting accesses finish in one cycle.
module mem_stage #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input logic        clk,
  input logic        rst_n,
  mem_stage_if.slave bus
);

  localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic [63:0] ram [DEPTH];

  logic [63:0] wb_alu_result_q;
  logic [63:0] wb_read_data_q;
  logic [4:0]  wb_rd_q;
  logic        wb_memtoreg_q;
  logic        wb_regwrite_q;
  logic        wb_overflow_q;
  logic        fault_q;

  logic [ADDR_W-1:0] idx;
  logic              misaligned;
  logic              out_of_range;
  logic              is_mem;
  logic              fault;
  logic              valid_mem;
  logic              stall;
  logic              ram_we;

  always_comb begin
    idx          = bus.ex_mem_alu_result[ADDR_W+2:3];
    misaligned   = |bus.ex_mem_alu_result[2:0];
    out_of_range = |bus.ex_mem_alu_result[63:ADDR_W+3];
    is_mem       = bus.ex_mem_Memread | bus.ex_mem_Memwrite;
    fault        = is_mem & (misaligned | out_of_range |
                             (bus.ex_mem_Memread & bus.ex_mem_Memwrite));
    valid_mem    = is_mem & ~fault;
  end

  // Stall is combinational so the issuing cycle already freezes upstream; reset drops it at once.
  always_comb begin
    stall = 1'b0;
    if (rst_n) begin
      if (state_q == BUSY) begin
        stall = (cnt_q != '0);
      end else begin
        stall = valid_mem && (MEM_LATENCY > 1);
      end
    end
  end

  assign ram_we = rst_n & ~stall & valid_mem & bus.ex_mem_Memwrite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (state_q == IDLE) begin
      if (stall) begin
        state_q <= BUSY;
        cnt_q   <= CNT_INIT;
      end
    end else begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        state_q <= IDLE;
      end
    end
  end

  // Data array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[idx] <= bus.ex_mem_rs2_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_alu_result_q <= '0;
      wb_read_data_q  <= '0;
      wb_rd_q         <= '0;
      wb_memtoreg_q   <= 1'b0;
      wb_regwrite_q   <= 1'b0;
      wb_overflow_q   <= 1'b0;
      fault_q         <= 1'b0;
    end else if (stall) begin
      wb_memtoreg_q <= 1'b0;
      wb_regwrite_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      wb_alu_result_q <= bus.ex_mem_alu_result;
      wb_rd_q         <= bus.ex_mem_rd;
      wb_memtoreg_q   <= bus.ex_mem_MemtoReg;
      wb_overflow_q   <= bus.ex_mem_overflow;
      wb_regwrite_q   <= bus.ex_mem_Regwrite & ~fault;
      wb_read_data_q  <= (valid_mem && bus.ex_mem_Memread) ? ram[idx] : '0;
      fault_q         <= fault;
    end
  end

  assign bus.mem_wb_alu_result = wb_alu_result_q;
  assign bus.mem_wb_read_data  = wb_read_data_q;
  assign bus.mem_wb_rd         = wb_rd_q;
  assign bus.mem_wb_MemtoReg   = wb_memtoreg_q;
  assign bus.mem_wb_Regwrite   = wb_regwrite_q;
  assign bus.mem_wb_overflow   = wb_overflow_q;
  assign bus.mem_stall         = stall;
  assign bus.mem_fault         = fault_q;

endmodule
